// File: rtl/decode_stage.sv
// Registered instruction-decode stage: valid/ready handshake, load-use and SPI-busy
// interlocks, flush, illegal-op flagging and a saturating hazard stall counter.
module decode_stage #(
   parameter int W_CPU         = 32,
   parameter int W_REG         = 5,
   parameter int W_STALL       = 16,
   parameter int SPI_INTERLOCK = 1,
   parameter int W_IMM_EXT     = 2,
   parameter int W_IMM         = 16,
   parameter int W_JADDR       = 26,
   parameter int W_FUNCT       = 6,
   parameter int W_SPI         = 1,
   parameter int W_PC_SRC      = 3,
   parameter int W_MEM         = 2,
   parameter int W_ALU_SRC     = 2,
   parameter int W_REG_SRC     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [W_CPU-1:0]     inst,
   input  logic [W_CPU-1:0]     pc_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   input  logic                 flush,
   input  logic                 ex_load_valid,
   input  logic [W_REG-1:0]     ex_load_wa,
   input  logic                 spi_busy,
   output logic [W_REG-1:0]     wa,
   output logic [W_REG-1:0]     ra1,
   output logic [W_REG-1:0]     ra2,
   output logic                 reg_wen,
   output logic [W_IMM_EXT-1:0] imm_ext,
   output logic [W_IMM-1:0]     imm,
   output logic [W_JADDR-1:0]   addr,
   output logic [W_FUNCT-1:0]   alu_op,
   output logic [W_SPI-1:0]     spi_mode,
   output logic [W_PC_SRC-1:0]  pc_src,
   output logic [W_MEM-1:0]     mem_cmd,
   output logic [W_ALU_SRC-1:0] alu_src,
   output logic [W_REG_SRC-1:0] reg_src,
   output logic [W_CPU-1:0]     pc_out,
   output logic                 illegal,
   output logic [W_STALL-1:0]   stall_cnt
);

   localparam logic WREN = 1'b1;
   localparam logic WDIS = 1'b0;
   localparam logic [W_IMM_EXT-1:0] IMM_ZE  = W_IMM_EXT'(0);
   localparam logic [W_IMM_EXT-1:0] IMM_SE  = W_IMM_EXT'(1);
   localparam logic [W_IMM_EXT-1:0] IMM_LUI = W_IMM_EXT'(2);
   localparam logic [W_SPI-1:0] SPI_SEND    = W_SPI'(0);
   localparam logic [W_SPI-1:0] SPI_RECEIVE = W_SPI'(1);
   localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT = W_PC_SRC'(0);
   localparam logic [W_PC_SRC-1:0] PC_SRC_BEQ  = W_PC_SRC'(1);
   localparam logic [W_PC_SRC-1:0] PC_SRC_BNE  = W_PC_SRC'(2);
   localparam logic [W_PC_SRC-1:0] PC_SRC_JUMP = W_PC_SRC'(3);
   localparam logic [W_PC_SRC-1:0] PC_SRC_JR   = W_PC_SRC'(4);
   localparam logic [W_MEM-1:0] MEM_NOP   = W_MEM'(0);
   localparam logic [W_MEM-1:0] MEM_LOAD  = W_MEM'(1);
   localparam logic [W_MEM-1:0] MEM_STORE = W_MEM'(2);
   localparam logic [W_ALU_SRC-1:0] ALU_SRC_REG = W_ALU_SRC'(0);
   localparam logic [W_ALU_SRC-1:0] ALU_SRC_IMM = W_ALU_SRC'(1);
   localparam logic [W_ALU_SRC-1:0] ALU_SRC_SHA = W_ALU_SRC'(2);
   localparam logic [W_REG_SRC-1:0] REG_SRC_ALU = W_REG_SRC'(0);
   localparam logic [W_REG_SRC-1:0] REG_SRC_MEM = W_REG_SRC'(1);
   localparam logic [W_REG_SRC-1:0] REG_SRC_PC  = W_REG_SRC'(2);
   localparam logic [W_REG_SRC-1:0] REG_SRC_SPI = W_REG_SRC'(3);
   localparam logic [W_FUNCT-1:0] F_SLL  = W_FUNCT'(6'h00);
   localparam logic [W_FUNCT-1:0] F_SRL  = W_FUNCT'(6'h02);
   localparam logic [W_FUNCT-1:0] F_JR   = W_FUNCT'(6'h08);
   localparam logic [W_FUNCT-1:0] F_ADD  = W_FUNCT'(6'h20);
   localparam logic [W_FUNCT-1:0] F_ADDU = W_FUNCT'(6'h21);
   localparam logic [W_FUNCT-1:0] F_SUB  = W_FUNCT'(6'h22);
   localparam logic [W_FUNCT-1:0] F_SUBU = W_FUNCT'(6'h23);
   localparam logic [W_FUNCT-1:0] F_AND  = W_FUNCT'(6'h24);
   localparam logic [W_FUNCT-1:0] F_OR   = W_FUNCT'(6'h25);
   localparam logic [W_FUNCT-1:0] F_XOR  = W_FUNCT'(6'h26);
   localparam logic [W_FUNCT-1:0] F_NOR  = W_FUNCT'(6'h27);
   localparam logic [W_FUNCT-1:0] F_SLT  = W_FUNCT'(6'h2a);
   localparam logic [W_FUNCT-1:0] F_SLTU = W_FUNCT'(6'h2b);
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d, OP_LUI  = 6'h0f, OP_COP0 = 6'h10;
   localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2b;

   typedef struct packed {
      logic [W_REG-1:0]     wa;
      logic [W_REG-1:0]     ra1;
      logic [W_REG-1:0]     ra2;
      logic                 reg_wen;
      logic [W_IMM_EXT-1:0] imm_ext;
      logic [W_IMM-1:0]     imm;
      logic [W_JADDR-1:0]   addr;
      logic [W_FUNCT-1:0]   alu_op;
      logic [W_SPI-1:0]     spi_mode;
      logic [W_PC_SRC-1:0]  pc_src;
      logic [W_MEM-1:0]     mem_cmd;
      logic [W_ALU_SRC-1:0] alu_src;
      logic [W_REG_SRC-1:0] reg_src;
      logic                 illegal;
   } bundle_t;

   // Every NOP encoding is zero, so the all-zero bundle is the NOP bundle.
   localparam bundle_t NOP_BUNDLE = '0;

   typedef enum logic [1:0] {S_EMPTY, S_FULL, S_STALL} state_t;

   function automatic logic [W_STALL-1:0] sat_inc(input logic [W_STALL-1:0] v);
      return (&v) ? v : v + W_STALL'(1);
   endfunction

   logic [5:0]         op;
   logic [W_REG-1:0]   rs, rt, rd;
   logic [W_FUNCT-1:0] funct;
   bundle_t            dec_p0, bnd_p1;
   logic [W_CPU-1:0]   pc_p1;
   logic               reads_rt_p0;
   logic               load_use, spi_hold, hazard, accept;
   logic               vld_p1, vld_d;
   state_t             state_q, state_d;
   logic [W_STALL-1:0] stall_q;

   assign op    = inst[31:26];
   assign rs    = inst[25:21];
   assign rt    = inst[20:16];
   assign rd    = inst[15:11];
   assign funct = inst[W_FUNCT-1:0];

   always_comb begin
      dec_p0      = NOP_BUNDLE;
      reads_rt_p0 = 1'b0;
      case (op)
         OP_RTYPE: begin
            reads_rt_p0    = 1'b1;
            dec_p0.wa      = rd;
            dec_p0.ra1     = rs;
            dec_p0.ra2     = rt;
            dec_p0.reg_wen = WREN;
            dec_p0.alu_op  = funct;
            dec_p0.alu_src = ALU_SRC_REG;
            dec_p0.reg_src = REG_SRC_ALU;
            case (funct)
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ;
               F_SLL, F_SRL: begin
                  dec_p0.ra1     = rt;
                  dec_p0.alu_src = ALU_SRC_SHA;
                  dec_p0.imm     = inst[W_IMM-1:0];
               end
               F_JR: begin
                  dec_p0.wa      = '0;
                  dec_p0.reg_wen = WDIS;
                  dec_p0.alu_op  = '0;
                  dec_p0.pc_src  = PC_SRC_JR;
               end
               default: begin
                  dec_p0         = NOP_BUNDLE;
                  dec_p0.illegal = 1'b1;
                  reads_rt_p0    = 1'b0;
               end
            endcase
         end
         OP_J, OP_JAL: begin
            dec_p0.addr   = inst[W_JADDR-1:0];
            dec_p0.pc_src = PC_SRC_JUMP;
            if (op == OP_JAL) begin
               dec_p0.wa      = W_REG'(31);
               dec_p0.reg_wen = WREN;
               dec_p0.reg_src = REG_SRC_PC;
            end
         end
         OP_BEQ, OP_BNE: begin
            reads_rt_p0    = 1'b1;
            dec_p0.ra1     = rs;
            dec_p0.ra2     = rt;
            dec_p0.imm     = inst[W_IMM-1:0];
            dec_p0.imm_ext = IMM_SE;
            dec_p0.alu_op  = F_SUB;
            dec_p0.pc_src  = (op == OP_BEQ) ? PC_SRC_BEQ : PC_SRC_BNE;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: begin
            dec_p0.wa      = rt;
            dec_p0.ra1     = rs;
            dec_p0.ra2     = rt;
            dec_p0.reg_wen = WREN;
            dec_p0.imm     = inst[W_IMM-1:0];
            dec_p0.imm_ext = IMM_SE;
            dec_p0.alu_op  = F_ADD;
            dec_p0.alu_src = ALU_SRC_IMM;
            case (op)
               OP_ADDIU: dec_p0.alu_op = F_ADDU;
               OP_SLTI:  dec_p0.alu_op = F_SLT;
               OP_ANDI:  begin dec_p0.imm_ext = IMM_ZE;  dec_p0.alu_op = F_AND; end
               OP_ORI:   begin dec_p0.imm_ext = IMM_ZE;  dec_p0.alu_op = F_OR;  end
               OP_LUI:   begin dec_p0.imm_ext = IMM_LUI; dec_p0.alu_op = F_OR;  end
               OP_LW:    begin dec_p0.mem_cmd = MEM_LOAD; dec_p0.reg_src = REG_SRC_MEM; end
               OP_SW: begin
                  dec_p0.mem_cmd = MEM_STORE;
                  dec_p0.reg_wen = WDIS;
                  reads_rt_p0    = 1'b1;
               end
               default: ;
            endcase
         end
         OP_COP0: begin
            if (rs == W_REG'(0)) begin
               dec_p0.wa       = rt;
               dec_p0.reg_wen  = WREN;
               dec_p0.spi_mode = SPI_RECEIVE;
               dec_p0.reg_src  = REG_SRC_SPI;
            end else if (rs == W_REG'(4)) begin
               reads_rt_p0     = 1'b1;
               dec_p0.ra2      = rt;
               dec_p0.spi_mode = SPI_SEND;
            end else begin
               dec_p0.illegal  = 1'b1;
            end
         end
         default: dec_p0.illegal = 1'b1;
      endcase
   end

   assign load_use = ex_load_valid && (ex_load_wa != '0) &&
                     ((ex_load_wa == rs) || ((ex_load_wa == rt) && reads_rt_p0));
   assign spi_hold = (SPI_INTERLOCK != 0) && spi_busy && (op == OP_COP0);
   assign hazard   = load_use || spi_hold;
   assign in_ready = rst_n && !flush && !hazard && (!vld_p1 || out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      vld_d   = vld_p1;
      if (flush) begin
         state_d = S_EMPTY;
         vld_d   = 1'b0;
      end else if (accept) begin
         state_d = S_FULL;
         vld_d   = 1'b1;
      end else if (in_valid && hazard) begin
         state_d = S_STALL;
         vld_d   = vld_p1 && !out_ready;
      end else begin
         vld_d   = vld_p1 && !out_ready;
         state_d = vld_d ? S_FULL : S_EMPTY;
      end
   end

   // p0 -> p1: control state, registered bundle and stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         vld_p1  <= 1'b0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         vld_p1  <= vld_d;
         if (in_valid && hazard && !flush) stall_q <= sat_inc(stall_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bnd_p1 <= NOP_BUNDLE;
         pc_p1  <= '0;
      end else if (accept) begin
         bnd_p1 <= dec_p0;
         pc_p1  <= pc_in;
      end
   end

   assign out_valid = vld_p1;
   assign wa        = bnd_p1.wa;
   assign ra1       = bnd_p1.ra1;
   assign ra2       = bnd_p1.ra2;
   assign reg_wen   = bnd_p1.reg_wen;
   assign imm_ext   = bnd_p1.imm_ext;
   assign imm       = bnd_p1.imm;
   assign addr      = bnd_p1.addr;
   assign alu_op    = bnd_p1.alu_op;
   assign spi_mode  = bnd_p1.spi_mode;
   assign pc_src    = bnd_p1.pc_src;
   assign mem_cmd   = bnd_p1.mem_cmd;
   assign alu_src   = bnd_p1.alu_src;
   assign reg_src   = bnd_p1.reg_src;
   assign illegal   = bnd_p1.illegal;
   assign pc_out    = pc_p1;
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of decoded bundles checked through a scoreboard,
// plus hand sequences for stalls, hold, SPI interlock, flush and counter saturation.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst_n, in_valid, out_ready, flush, ex_load_valid, spi_busy;
   logic [4:0]  ex_load_wa;
   logic [31:0] inst, pc_in;

   logic in_ready, out_valid, reg_wen, illegal;
   logic [4:0] wa, ra1, ra2;
   logic [1:0] imm_ext, mem_cmd, alu_src, reg_src;
   logic [15:0] imm;
   logic [25:0] addr;
   logic [5:0] alu_op;
   logic [0:0] spi_mode;
   logic [2:0] pc_src;
   logic [31:0] pc_out;
   logic [15:0] stall_cnt;

   logic d1_in_ready, d1_out_valid, d1_reg_wen, d1_illegal;
   logic [4:0] d1_wa, d1_ra1, d1_ra2;
   logic [1:0] d1_imm_ext, d1_mem_cmd, d1_alu_src, d1_reg_src;
   logic [15:0] d1_imm;
   logic [25:0] d1_addr;
   logic [5:0] d1_alu_op;
   logic [0:0] d1_spi_mode;
   logic [2:0] d1_pc_src;
   logic [31:0] d1_pc_out;
   logic [1:0] d1_stall_cnt;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
      .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
      .ex_load_valid(ex_load_valid), .ex_load_wa(ex_load_wa), .spi_busy(spi_busy),
      .wa(wa), .ra1(ra1), .ra2(ra2), .reg_wen(reg_wen), .imm_ext(imm_ext), .imm(imm),
      .addr(addr), .alu_op(alu_op), .spi_mode(spi_mode), .pc_src(pc_src),
      .mem_cmd(mem_cmd), .alu_src(alu_src), .reg_src(reg_src), .pc_out(pc_out),
      .illegal(illegal), .stall_cnt(stall_cnt));

   decode_stage #(.W_STALL(2), .SPI_INTERLOCK(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready), .inst(inst),
      .pc_in(pc_in), .out_valid(d1_out_valid), .out_ready(out_ready), .flush(flush),
      .ex_load_valid(ex_load_valid), .ex_load_wa(ex_load_wa), .spi_busy(spi_busy),
      .wa(d1_wa), .ra1(d1_ra1), .ra2(d1_ra2), .reg_wen(d1_reg_wen), .imm_ext(d1_imm_ext),
      .imm(d1_imm), .addr(d1_addr), .alu_op(d1_alu_op), .spi_mode(d1_spi_mode),
      .pc_src(d1_pc_src), .mem_cmd(d1_mem_cmd), .alu_src(d1_alu_src),
      .reg_src(d1_reg_src), .pc_out(d1_pc_out), .illegal(d1_illegal),
      .stall_cnt(d1_stall_cnt));

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  wa, ra1, ra2;
      logic        wen;
      logic [1:0]  ext;
      logic [15:0] imm;
      logic [25:0] addr;
      logic [5:0]  op;
      logic        spi;
      logic [2:0]  pcs;
      logic [1:0]  mem, asrc, rsrc;
      logic        ill;
      logic [31:0] pc;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];
   vec_t sb [$];
   vec_t cur;
   int errors = 0;
   int checks = 0;
   logic [127:0] dut_bus;

   assign dut_bus = {19'b0, wa, ra1, ra2, reg_wen, imm_ext, imm, addr, alu_op, spi_mode,
                     pc_src, mem_cmd, alu_src, reg_src, illegal, pc_out};

   function automatic logic [127:0] pack_exp(input vec_t v);
      return {19'b0, v.wa, v.ra1, v.ra2, v.wen, v.ext, v.imm, v.addr, v.op, v.spi,
              v.pcs, v.mem, v.asrc, v.rsrc, v.ill, v.pc};
   endfunction

   function automatic vec_t mk(input logic [31:0] i, input logic [4:0] w, r1, r2,
                               input logic wen, input logic [1:0] ext, input logic [15:0] im,
                               input logic [25:0] ad, input logic [5:0] op, input logic spi,
                               input logic [2:0] pcs, input logic [1:0] mem, asrc, rsrc,
                               input logic ill);
      vec_t v;
      v.inst = i; v.wa = w; v.ra1 = r1; v.ra2 = r2; v.wen = wen; v.ext = ext; v.imm = im;
      v.addr = ad; v.op = op; v.spi = spi; v.pcs = pcs; v.mem = mem; v.asrc = asrc;
      v.rsrc = rsrc; v.ill = ill; v.pc = '0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_vec(input int i);
      inst     = tbl[i].inst;
      pc_in    = 32'h1000 + 32'(i * 4);
      cur      = tbl[i];
      cur.pc   = pc_in;
      in_valid = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: push on accept, pop when execute consumes a valid bundle.
   always @(negedge clk) begin
      if (!rst_n) sb.delete();
      else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got out_valid=1 expected no bundle");
            end else begin
               vec_t e;
               e = sb.pop_front();
               chk("bundle", dut_bus, pack_exp(e));
            end
         end
         if (flush) sb.delete();
         if (in_valid && in_ready) sb.push_back(cur);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      //          inst          wa  r1  r2 wen ext imm       addr      op     spi pcs mem as rs ill
      tbl[0]  = mk(32'h20080005, 8,  0,  8, 1, 1, 16'h0005, 26'h0,    6'h20, 0, 0, 0, 1, 0, 0);
      tbl[1]  = mk(32'h01295020, 10, 9,  9, 1, 0, 16'h0000, 26'h0,    6'h20, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(32'h00094100, 8,  9,  9, 1, 0, 16'h4100, 26'h0,    6'h00, 0, 0, 0, 2, 0, 0);
      tbl[3]  = mk(32'h8D0B0008, 11, 8, 11, 1, 1, 16'h0008, 26'h0,    6'h20, 0, 0, 1, 1, 1, 0);
      tbl[4]  = mk(32'hAD0B000C, 11, 8, 11, 0, 1, 16'h000C, 26'h0,    6'h20, 0, 0, 2, 1, 0, 0);
      tbl[5]  = mk(32'h1109FFFF, 0,  8,  9, 0, 1, 16'hFFFF, 26'h0,    6'h22, 0, 1, 0, 0, 0, 0);
      tbl[6]  = mk(32'h1509FFFE, 0,  8,  9, 0, 1, 16'hFFFE, 26'h0,    6'h22, 0, 2, 0, 0, 0, 0);
      tbl[7]  = mk(32'h0C000040, 31, 0,  0, 1, 0, 16'h0000, 26'h40,   6'h00, 0, 3, 0, 0, 2, 0);
      tbl[8]  = mk(32'h08000123, 0,  0,  0, 0, 0, 16'h0000, 26'h123,  6'h00, 0, 3, 0, 0, 0, 0);
      tbl[9]  = mk(32'h03E00008, 0, 31,  0, 0, 0, 16'h0000, 26'h0,    6'h00, 0, 4, 0, 0, 0, 0);
      tbl[10] = mk(32'h35288001, 8,  9,  8, 1, 0, 16'h8001, 26'h0,    6'h25, 0, 0, 0, 1, 0, 0);
      tbl[11] = mk(32'h40080000, 8,  0,  0, 1, 0, 16'h0000, 26'h0,    6'h00, 1, 0, 0, 0, 3, 0);
      tbl[12] = mk(32'h40890000, 0,  0,  9, 0, 0, 16'h0000, 26'h0,    6'h00, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(32'hFC000000, 0,  0,  0, 0, 0, 16'h0000, 26'h0,    6'h00, 0, 0, 0, 0, 0, 1);
      tbl[14] = mk(32'h0000003F, 0,  0,  0, 0, 0, 16'h0000, 26'h0,    6'h00, 0, 0, 0, 0, 0, 1);
      tbl[15] = mk(32'h40280000, 0,  0,  0, 0, 0, 16'h0000, 26'h0,    6'h00, 0, 0, 0, 0, 0, 1);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
      ex_load_valid = 1'b0; ex_load_wa = '0; spi_busy = 1'b0; inst = '0; pc_in = '0;
      cur = tbl[0];

      // Reset state, with an instruction offered
      set_vec(0);
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_bundle", {reg_wen, illegal, mem_cmd, pc_out}, 0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;

      // Table vectors back to back
      for (int i = 0; i < NV; i++) begin
         set_vec(i);
         @(negedge clk);
         chk("tput_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("drain_valid", out_valid, 0);
      chk("drain_sb", sb.size(), 0);
      tick();

      // Load-use: one bubble
      set_vec(1);
      ex_load_valid = 1'b1; ex_load_wa = 5'd9;
      @(negedge clk);
      chk("lu_ready0", in_ready, 0);
      tick();
      ex_load_valid = 1'b0;
      @(negedge clk);
      chk("lu_stall_cnt", stall_cnt, 1);
      chk("lu_stall_cnt_d1", d1_stall_cnt, 1);
      chk("lu_ready1", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("lu_out", {out_valid, wa}, {1'b1, 5'd10});
      tick();

      // Held bundle under back-pressure
      out_ready = 1'b0;
      set_vec(0);
      tick();
      set_vec(10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_bundle", {out_valid, wa, imm, pc_out}, {1'b1, 5'd8, 16'h0005, 32'h1000});
         chk("hold_ready", in_ready, 0);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("no_bubble", {out_valid, imm}, {1'b1, 16'h8001});
      tick();

      // SPI interlock: dut holds, dut1 (interlock off) accepts at once
      spi_busy = 1'b1;
      set_vec(11);
      @(negedge clk);
      chk("spi_ready", in_ready, 0);
      chk("spi_ready_d1", d1_in_ready, 1);
      tick();
      @(negedge clk);
      chk("spi_d1_out", {d1_out_valid, d1_spi_mode, d1_wa}, {1'b1, 1'b1, 5'd8});
      chk("spi_still_held", in_ready, 0);
      tick();
      spi_busy = 1'b0;
      @(negedge clk);
      chk("spi_go", in_ready, 1);
      chk("spi_stall_cnt", stall_cnt, 3);
      chk("spi_stall_cnt_d1", d1_stall_cnt, 1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mfc0_out", {out_valid, spi_mode, wa}, {1'b1, 1'b1, 5'd8});
      tick();

      // Flush while full with an instruction offered
      out_ready = 1'b0;
      set_vec(0);
      tick();
      set_vec(10);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_ready", {in_ready, out_valid}, {1'b0, 1'b1});
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", out_valid, 0);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_nothing", {out_valid, 32'(sb.size())}, 0);
      tick();

      // Saturation on the 2-bit counter, then reset mid-stall
      out_ready = 1'b0;
      set_vec(0);
      tick();
      set_vec(1);
      ex_load_valid = 1'b1; ex_load_wa = 5'd9;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("sat_d1", d1_stall_cnt, (k < 2) ? 1 + k : 3);
         chk("sat_d0", stall_cnt, 3 + k);
      end
      chk("stall_held_valid", out_valid, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_stall", {stall_cnt, 14'b0, d1_stall_cnt, out_valid, d1_out_valid, in_ready},
          0);
      @(negedge clk);
      ex_load_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst", {out_valid, stall_cnt}, 0);
      chk("final_sb", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
